// File: rtl/da2_spi_pkg.sv
//------------------------------------------------------------------------------
// Module  : da2_spi_pkg
// Brief   : Shared types, frame constants and helpers for the PmodDA2 SPI path.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package da2_spi_pkg;

    typedef enum logic [2:0] {
        S_HOLD        = 3'd0,
        S_IDLE        = 3'd1,
        S_FRONT_PORCH = 3'd2,
        S_SHIFTING    = 3'd3,
        S_BACK_PORCH  = 3'd4
    } state_t;

    localparam int c_FRAME_W = 16;
    localparam int c_BIT_W   = $clog2(c_FRAME_W);

    // DAC121S101 power-down codes (bits 13:12 of the frame)
    localparam logic [1:0] c_PD_NORMAL = 2'b00;
    localparam logic [1:0] c_PD_HIZ    = 2'b11;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    function automatic logic [c_FRAME_W-1:0] make_frame(input logic [1:0] pd,
                                                        input logic [11:0] din);
        return {2'b00, pd, din};
    endfunction

endpackage

`default_nettype wire

// File: rtl/da2_spi_phase_timer.sv
//------------------------------------------------------------------------------
// Module  : da2_spi_phase_timer
// Brief   : Cycle/bit counters for SPI phase timing (porches and bit periods).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module da2_spi_phase_timer
    import da2_spi_pkg::*;
#(
    parameter int CLOCKS_PER_BIT = 20,
    parameter int CNT_W          = 9
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             restart,
    input  logic             run,
    input  logic             shifting,
    input  logic [CNT_W-1:0] length,
    output logic             phase_done,
    output logic             phase_next_done,
    output logic             bit_half,
    output logic             bit_end,
    output logic             bit_last
);

    localparam logic [CNT_W-1:0]   c_HALF_M1 = CNT_W'(CLOCKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]   c_BIT_M1  = CNT_W'(CLOCKS_PER_BIT - 1);
    localparam logic [c_BIT_W-1:0] c_LAST    = c_BIT_W'(c_FRAME_W - 1);

    logic [CNT_W-1:0]   r_cnt;
    logic [c_BIT_W-1:0] r_bit;

    // restart wins over the bit wrap so the bit counter never rolls past 15
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
            r_bit <= '0;
        end else if (restart) begin
            r_cnt <= '0;
            r_bit <= '0;
        end else if (shifting && (r_cnt == c_BIT_M1)) begin
            r_cnt <= '0;
            r_bit <= r_bit + c_BIT_W'(1);
        end else if (run) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign phase_done      = (r_cnt == (length - CNT_W'(1)));
    assign phase_next_done = ((r_cnt + CNT_W'(2)) == length);
    assign bit_half        = shifting && (r_cnt == c_HALF_M1);
    assign bit_end         = shifting && (r_cnt == c_BIT_M1);
    assign bit_last        = (r_bit == c_LAST);

endmodule

`default_nettype wire

// File: rtl/da2_spi.sv
//------------------------------------------------------------------------------
// Module  : da2_spi
// Brief   : Continuous-update dual-channel SPI transmitter for the PmodDA2.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module da2_spi
    import da2_spi_pkg::*;
#(
    parameter int CLOCKS_PER_BIT              = 20,
    parameter int CLOCKS_BEFORE_DATA          = 10,
    parameter int CLOCKS_AFTER_DATA           = 10,
    parameter int CLOCKS_BETWEEN_TRANSACTIONS = 5
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [11:0] din0,
    input  logic [11:0] din1,
    input  logic [1:0]  pd,
    input  logic        valid,
    output logic        ready,
    output logic        done,
    output logic        cs,
    output logic        sclk,
    output logic        sdout0,
    output logic        sdout1
);

    localparam int c_MAX   = max4(CLOCKS_PER_BIT, CLOCKS_BEFORE_DATA,
                                  CLOCKS_AFTER_DATA, CLOCKS_BETWEEN_TRANSACTIONS);
    localparam int c_CNT_W = $clog2(c_MAX + 2);

    localparam logic [c_CNT_W-1:0] c_LEN_FRONT = c_CNT_W'(CLOCKS_BEFORE_DATA);
    localparam logic [c_CNT_W-1:0] c_LEN_BACK  = c_CNT_W'(CLOCKS_AFTER_DATA);
    localparam logic [c_CNT_W-1:0] c_LEN_HOLD  = c_CNT_W'(CLOCKS_BETWEEN_TRANSACTIONS);
    localparam logic               c_DONE_ON_ENTRY = (CLOCKS_AFTER_DATA == 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_FRAME_W-1:0]  r_sh0;
    logic [c_FRAME_W-1:0]  r_sh1;
    logic                  r_cs;
    logic                  r_sclk;
    logic                  r_ready;
    logic                  r_done;
    logic                  w_cs_nxt;
    logic                  w_sclk_nxt;
    logic                  w_ready_nxt;
    logic                  w_done_nxt;
    logic                  w_load;
    logic                  w_shift;
    logic                  w_clear;
    logic                  w_restart;
    logic [c_CNT_W-1:0]    w_length;
    logic                  w_run;
    logic                  w_shifting;
    logic                  w_phase_done;
    logic                  w_phase_next_done;
    logic                  w_bit_half;
    logic                  w_bit_end;
    logic                  w_bit_last;

    assign w_run      = (r_state != S_IDLE);
    assign w_shifting = (r_state == S_SHIFTING);

    da2_spi_phase_timer #(
        .CLOCKS_PER_BIT (CLOCKS_PER_BIT),
        .CNT_W          (c_CNT_W)
    ) u_timer (
        .clk             (clk),
        .rstn            (rstn),
        .restart         (w_restart),
        .run             (w_run),
        .shifting        (w_shifting),
        .length          (w_length),
        .phase_done      (w_phase_done),
        .phase_next_done (w_phase_next_done),
        .bit_half        (w_bit_half),
        .bit_end         (w_bit_end),
        .bit_last        (w_bit_last)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_restart   = 1'b0;
        w_length    = c_LEN_HOLD;
        w_cs_nxt    = r_cs;
        w_sclk_nxt  = r_sclk;
        w_ready_nxt = r_ready;
        w_done_nxt  = 1'b0;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_clear     = 1'b0;
        case (r_state)
            S_HOLD: begin
                w_length = c_LEN_HOLD;
                if (w_phase_done) begin
                    w_state_nxt = S_IDLE;
                    w_restart   = 1'b1;
                    w_ready_nxt = 1'b1;
                end
            end
            S_IDLE: begin
                if (valid && r_ready) begin
                    w_state_nxt = S_FRONT_PORCH;
                    w_restart   = 1'b1;
                    w_load      = 1'b1;
                    w_ready_nxt = 1'b0;
                    w_cs_nxt    = 1'b0;
                end
            end
            S_FRONT_PORCH: begin
                w_length = c_LEN_FRONT;
                if (w_phase_done) begin
                    w_state_nxt = S_SHIFTING;
                    w_restart   = 1'b1;
                end
            end
            S_SHIFTING: begin
                // sclk drops mid-bit; data only moves at the bit boundary
                if (w_bit_half) begin
                    w_sclk_nxt = 1'b0;
                end
                if (w_bit_end) begin
                    w_sclk_nxt = 1'b1;
                    if (w_bit_last) begin
                        w_state_nxt = S_BACK_PORCH;
                        w_restart   = 1'b1;
                        w_clear     = 1'b1;
                        w_done_nxt  = c_DONE_ON_ENTRY;
                    end else begin
                        w_shift = 1'b1;
                    end
                end
            end
            S_BACK_PORCH: begin
                w_length = c_LEN_BACK;
                if (w_phase_done) begin
                    w_state_nxt = S_HOLD;
                    w_restart   = 1'b1;
                    w_cs_nxt    = 1'b1;
                end else begin
                    w_done_nxt = w_phase_next_done;
                end
            end
            default: begin
                w_state_nxt = S_HOLD;
                w_restart   = 1'b1;
                w_cs_nxt    = 1'b1;
                w_sclk_nxt  = 1'b1;
                w_ready_nxt = 1'b0;
                w_clear     = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_HOLD;
            r_cs    <= 1'b1;
            r_sclk  <= 1'b1;
            r_ready <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cs    <= w_cs_nxt;
            r_sclk  <= w_sclk_nxt;
            r_ready <= w_ready_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // the MSB of each shift register is the data pin itself
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sh0 <= '0;
            r_sh1 <= '0;
        end else if (w_load) begin
            r_sh0 <= make_frame(pd, din0);
            r_sh1 <= make_frame(pd, din1);
        end else if (w_clear) begin
            r_sh0 <= '0;
            r_sh1 <= '0;
        end else if (w_shift) begin
            r_sh0 <= {r_sh0[c_FRAME_W-2:0], 1'b0};
            r_sh1 <= {r_sh1[c_FRAME_W-2:0], 1'b0};
        end
    end

    assign ready  = r_ready;
    assign done   = r_done;
    assign cs     = r_cs;
    assign sclk   = r_sclk;
    assign sdout0 = r_sh0[c_FRAME_W-1];
    assign sdout1 = r_sh1[c_FRAME_W-1];

endmodule

`default_nettype wire

// File: tb/tb_da2_spi.sv
//------------------------------------------------------------------------------
// Module  : tb_da2_spi
// Brief   : Self-checking bench for da2_spi with a falling-edge DAC slave model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_da2_spi;
    import da2_spi_pkg::*;

    logic        clk;
    logic        rstn;
    logic [11:0] din0;
    logic [11:0] din1;
    logic [1:0]  pd;
    logic        valid;
    logic        ready;
    logic        done;
    logic        cs;
    logic        sclk;
    logic        sdout0;
    logic        sdout1;

    int checks;
    int errors;

    da2_spi dut (
        .clk    (clk),
        .rstn   (rstn),
        .din0   (din0),
        .din1   (din1),
        .pd     (pd),
        .valid  (valid),
        .ready  (ready),
        .done   (done),
        .cs     (cs),
        .sclk   (sclk),
        .sdout0 (sdout0),
        .sdout1 (sdout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave model: samples the data lines once per sclk falling edge while cs is low
    logic [15:0] m_sh0, m_sh1;
    int          m_edges, m_low, m_high, m_done_cnt;
    logic        m_prev_cs, m_prev_sclk, m_prev_done;
    logic [15:0] cap0_q[$];
    logic [15:0] cap1_q[$];
    int          edges_q[$];
    int          low_q[$];
    int          gap_q[$];
    logic        lastdone_q[$];

    initial begin
        m_sh0 = '0; m_sh1 = '0; m_edges = 0; m_low = 0; m_high = 0; m_done_cnt = 0;
        m_prev_cs = 1'b1; m_prev_sclk = 1'b1; m_prev_done = 1'b0;
    end

    always @(negedge clk) begin
        if (cs === 1'b0) begin
            if (m_prev_cs !== 1'b0) begin
                gap_q.push_back(m_high);
                m_low = 0; m_edges = 0; m_sh0 = '0; m_sh1 = '0;
            end
            m_low++;
            if (sclk === 1'b0 && m_prev_sclk === 1'b1) begin
                m_edges++;
                m_sh0 = {m_sh0[14:0], sdout0};
                m_sh1 = {m_sh1[14:0], sdout1};
            end
        end else begin
            if (m_prev_cs === 1'b0) begin
                cap0_q.push_back(m_sh0);
                cap1_q.push_back(m_sh1);
                edges_q.push_back(m_edges);
                low_q.push_back(m_low);
                lastdone_q.push_back(m_prev_done);
                m_high = 0;
            end
            m_high++;
        end
        if (done === 1'b1) m_done_cnt++;
        m_prev_cs   = cs;
        m_prev_sclk = sclk;
        m_prev_done = done;
    end

    task automatic send(input logic [11:0] a, input logic [11:0] b, input logic [1:0] p);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) begin
            checks++; errors++;
            $display("FAIL send_wait_ready: ready=%b after %0d cycles, required 1", ready, n);
        end
        din0 = a; din1 = b; pd = p; valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        checks++;
        if (ready !== 1'b0 || cs !== 1'b0) begin
            errors++;
            $display("FAIL accept_edge: ready=%b cs=%b, required ready=0 cs=0", ready, cs);
        end
    endtask

    task automatic wait_frames(input int n);
        int k;
        k = 0;
        while (cap0_q.size() < n && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (cap0_q.size() < n) begin
            checks++; errors++;
            $display("FAIL frame_timeout: frames=%0d, required %0d", cap0_q.size(), n);
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $fatal(1, "frame timeout");
        end
    endtask

    task automatic check_frame(input string name, input logic [15:0] e0, input logic [15:0] e1);
        checks++;
        if (cap0_q[$] !== e0) begin
            errors++;
            $display("FAIL %s_ch0: got %h, required %h", name, cap0_q[$], e0);
        end
        checks++;
        if (cap1_q[$] !== e1) begin
            errors++;
            $display("FAIL %s_ch1: got %h, required %h", name, cap1_q[$], e1);
        end
        checks++;
        if (edges_q[$] != 16) begin
            errors++;
            $display("FAIL %s_edges: got %0d, required 16", name, edges_q[$]);
        end
        checks++;
        if (low_q[$] != 340) begin
            errors++;
            $display("FAIL %s_cs_low: got %0d cycles, required 340", name, low_q[$]);
        end
    endtask

    task automatic test_reset;
        int  lat;
        logic bad;
        valid = 1'b0; din0 = '0; din1 = '0; pd = c_PD_NORMAL;
        rstn = 1'b1;
        #3 rstn = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (cs !== 1'b1 || sclk !== 1'b1 || sdout0 !== 1'b0 || sdout1 !== 1'b0 ||
            ready !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: cs=%b sclk=%b sd0=%b sd1=%b ready=%b done=%b, required 1 1 0 0 0 0",
                     cs, sclk, sdout0, sdout1, ready, done);
        end
        rstn = 1'b1;
        lat = 0; bad = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (cs !== 1'b1 || sclk !== 1'b1) bad = 1'b1;
            if (ready === 1'b1) begin
                lat = i;
                break;
            end
        end
        checks++;
        if (lat != 5) begin
            errors++;
            $display("FAIL ready_latency: got %0d cycles, required 5", lat);
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL idle_lines: cs/sclk dropped during hold, required both high");
        end
    endtask

    task automatic test_basic;
        int d0;
        d0 = m_done_cnt;
        send(12'hA5C, 12'h3F0, c_PD_NORMAL);
        wait_frames(1);
        check_frame("basic", 16'h0A5C, 16'h03F0);
        checks++;
        if (m_done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL done_count: got %0d pulses, required 1", m_done_cnt - d0);
        end
        checks++;
        if (lastdone_q[$] !== 1'b1) begin
            errors++;
            $display("FAIL done_position: done before cs rise=%b, required 1", lastdone_q[$]);
        end
    endtask

    task automatic test_pd;
        int base;
        base = cap0_q.size();
        send(12'hFFF, 12'hFFF, c_PD_HIZ);
        wait_frames(base + 1);
        check_frame("pd_hiz", 16'h3FFF, 16'h3FFF);
    endtask

    task automatic test_back_to_back;
        logic [11:0] s0[3];
        logic [11:0] s1[3];
        logic [15:0] e0[3];
        logic [15:0] e1[3];
        int base, n;
        s0 = '{12'h123, 12'h800, 12'h001};
        s1 = '{12'hFED, 12'h7FF, 12'hC3C};
        e0 = '{16'h0123, 16'h0800, 16'h0001};
        e1 = '{16'h0FED, 16'h07FF, 16'h0C3C};
        base = cap0_q.size();
        din0 = s0[0]; din1 = s1[0]; pd = c_PD_NORMAL; valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (ready !== 1'b1 && n < 1000);
            @(posedge clk); #1;
            if (k < 2) begin
                din0 = s0[k+1]; din1 = s1[k+1];
            end else begin
                valid = 1'b0;
            end
        end
        wait_frames(base + 3);
        repeat (50) @(negedge clk);
        checks++;
        if (cap0_q.size() != base + 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d frames, required %0d", cap0_q.size() - base, 3);
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (cap0_q[base+k] !== e0[k] || cap1_q[base+k] !== e1[k]) begin
                errors++;
                $display("FAIL b2b_frame%0d: got %h/%h, required %h/%h",
                         k, cap0_q[base+k], cap1_q[base+k], e0[k], e1[k]);
            end
        end
        for (int k = 1; k < 3; k++) begin
            checks++;
            if (gap_q[base+k] < 5) begin
                errors++;
                $display("FAIL b2b_gap%0d: cs high %0d cycles, required >= 5", k, gap_q[base+k]);
            end
        end
    endtask

    task automatic test_toggle;
        int base, n;
        base = cap0_q.size();
        send(12'h5A3, 12'h0C7, 2'b01);
        n = 0;
        while (cs === 1'b0 && n < 1000) begin
            @(posedge clk); #1;
            din0  = 12'($urandom);
            din1  = 12'($urandom);
            pd    = 2'($urandom);
            valid = 1'($urandom);
            n++;
        end
        valid = 1'b0;
        wait_frames(base + 1);
        check_frame("toggle", 16'h15A3, 16'h10C7);
    endtask

    task automatic test_reset_mid;
        int base, n;
        base = cap0_q.size();
        send(12'hABC, 12'h456, c_PD_NORMAL);
        @(negedge clk);
        n = 0;
        while (m_edges < 7 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (cs !== 1'b1 || sclk !== 1'b1 || sdout0 !== 1'b0 || sdout1 !== 1'b0) begin
            errors++;
            $display("FAIL abort_values: cs=%b sclk=%b sd0=%b sd1=%b, required 1 1 0 0",
                     cs, sclk, sdout0, sdout1);
        end
        @(negedge clk);
        rstn = 1'b1;
        send(12'h7E1, 12'h18A, 2'b10);
        wait_frames(base + 2);
        check_frame("recover", 16'h27E1, 16'h218A);
        checks++;
        if (gap_q[base+1] < 5) begin
            errors++;
            $display("FAIL recover_gap: cs high %0d cycles, required >= 5", gap_q[base+1]);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_pd();
        test_back_to_back();
        test_toggle();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
